uart_mem_cmd_ctrl: RTL and testbench
====================================

Name: uart_mem_cmd_ctrl

Overview:
- Command sequencer between the UART peripheral (rx/tx FIFOs) and the VSCPU memory-load port.
- Parses ASCII host commands:
  - "R" + 4 hex address chars: read one 32-bit word and return it as 8 uppercase hex chars.
  - "W" + 8 hex data chars: write to the current address, then post-increment it.
- Decodes the address into agent SRAM bank / main-memory selects qualified by program_sel.
- Drives single-word read/write cycles with configurable read latency.

Parameters:
- RD_LATENCY, 1, cycles from mem_en (read) to mem_rdata valid; legal 1..4.
- TIMEOUT_CYCLES, 1000000, inter-character idle limit; used only with the optional feature.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- program_sel  input  2  target select: 11 agent_1 (3 banks), 10 control tower (5), 01 codemaker (4), 00 none
- rx_empty  input  1  UART rx FIFO empty
- r_data  input  8  UART rx FIFO head byte
- rd_uart  output  1  one-cycle pop of the rx FIFO
- tx_full  input  1  UART tx FIFO full
- w_data  output  8  byte to transmit
- wr_uart  output  1  one-cycle push into the tx FIFO
- mem_en  output  1  one-cycle memory access strobe
- mem_we  output  1  write qualifier, valid with mem_en
- mem_main_sel  output  1  access targets main memory
- mem_bank  output  4  SRAM bank index, addr[12:9]
- mem_addr  output  9  word index: addr[8:0] for SRAM, addr[5:0] zero-extended for main memory
- mem_wdata  output  32  write data
- mem_rdata  input  32  read data
- busy  output  1  state != IDLE
- err_cnt  output  8  saturating count of protocol errors

Behaviour:
- Reset values: all outputs 0; internal addr register = 0; state = IDLE.
- States: IDLE, CMD, ADDR, DATA, MWR, MRD, MWAIT, SEND.
- rx handling:
  - A byte is consumed when rx_empty=0: r_data is sampled and rd_uart is pulsed for 1 cycle.
  - No second pop is issued the next cycle (one-cycle gap after each pop).
- IDLE/CMD dispatch:
  - 'R'/'r' -> ADDR, nibble count cleared.
  - 'W'/'w' -> DATA.
  - Any other byte is discarded silently and the FSM stays in IDLE.
- Hex decode: '0'-'9', 'A'-'F', 'a'-'f'.
  - Valid char: nibble is shifted in MSB-first.
  - Invalid char in ADDR/DATA: abort to IDLE, err_cnt += 1 (saturates at FF), addr register unchanged.
- ADDR: after the 4th nibble the addr register is loaded with the 16-bit value -> MRD.
- DATA: after the 8th nibble -> MWR.
- Decode:
  - addr[13]=1: main memory, mem_main_sel=1.
  - Otherwise: bank = addr[12:9].
  - addr[15:14] ignored.
  - A bank is valid iff bank < bank count of the current program_sel; program_sel is sampled in MRD/MWR.
- MWR:
  - Valid target: one cycle mem_en=1, mem_we=1, mem_wdata = assembled word.
  - Invalid target: write dropped, err_cnt += 1.
  - Either way the addr register is incremented (16-bit wrap FFFF->0000), then -> IDLE.
- MRD:
  - Valid target: mem_en=1, mem_we=0 -> MWAIT.
  - MWAIT counts RD_LATENCY cycles, then captures mem_rdata.
  - Invalid target: captured word = 00000000, err_cnt += 1.
  - The addr register is not incremented by a read.
- SEND:
  - Emits 8 uppercase hex chars, MSB nibble first.
  - Each char is pushed only while tx_full=0 (wr_uart 1 cycle, w_data stable that cycle); stalls while tx_full=1.
  - After the 8th char -> IDLE.
- rx bytes arriving during MRD/MWAIT/SEND remain in the FIFO and are not popped.
- mem_* outputs are held at 0 whenever mem_en=0.
- Reset asserted mid-command: immediate return to reset values; a partial command is discarded.

Optional Feature:
- Macro: UART_MEM_CMD_TIMEOUT_EN.
- Defined:
  - A counter runs in ADDR/DATA and reloads on every byte consumed.
  - On reaching TIMEOUT_CYCLES with no new byte: abort to IDLE, err_cnt += 1.
- Undefined: no counter; ADDR/DATA wait indefinitely; TIMEOUT_CYCLES unused.

Test Plan:
- Reset: all outputs 0, busy=0, err_cnt=00.
- program_sel=11, send "R015E" (memory holds 0) -> mem_bank=0, mem_addr=15E, one mem_en read; tx carries "00000000".
- Send "W01234567" then "W89ABCDEF" -> writes to 15E then 15F; "R015F" returns "89ABCDEF".
- program_sel=11, "R0643" (bank 3 ≥ 3 banks) -> no mem_en, tx "00000000", err_cnt=01.
- Send "R01G5" -> abort at 'G', err_cnt=01, no mem_en; a following "R015E" works normally.
- Hold tx_full=1 for 50 cycles during SEND -> no wr_uart during the stall, all 8 chars delivered in order afterwards.
- Reset pulse after "W0123" -> returns to IDLE; a following "R2000" with program_sel=01 -> mem_main_sel=1, mem_addr=000.

Source files
------------

// File: rtl/uart_mem_cmd_ctrl.sv
// uart_mem_cmd_ctrl: turns ASCII host commands from the UART rx FIFO into
// single-word memory cycles on the VSCPU load port.
//   "R"+4 hex : load address, read one word, reply with 8 uppercase hex chars
//   "W"+8 hex : write word to current address, then post-increment address
// Optional inter-character timeout in ADDR/DATA: define UART_MEM_CMD_TIMEOUT_EN.
module uart_mem_cmd_ctrl #(
    parameter int RD_LATENCY     = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  program_sel,
    input  logic        rx_empty,
    input  logic [7:0]  r_data,
    output logic        rd_uart,
    input  logic        tx_full,
    output logic [7:0]  w_data,
    output logic        wr_uart,
    output logic        mem_en,
    output logic        mem_we,
    output logic        mem_main_sel,
    output logic [3:0]  mem_bank,
    output logic [8:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, MWR, MRD, MWAIT, SEND} state_t;

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : gBadLatency
        $error("RD_LATENCY must be in 1..4");
    end
    if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state_q;
    logic        gap_q;
    logic [7:0]  cmdByte_q;
    logic [2:0]  nibCnt_q;
    logic [31:0] shift_q;
    // Address bits 15:14 never influence decode and cannot carry into the
    // lower bits, so only bits 13:0 of the 16-bit address are kept.
    logic [13:0] addr_q;
    logic [2:0]  waitCnt_q;
    logic [2:0]  sendIdx_q;
    logic        rdUart_q;
    logic [7:0]  wData_q;
    logic        wrUart_q;
    logic        memEn_q;
    logic        memWe_q;
    logic        memMainSel_q;
    logic [3:0]  memBank_q;
    logic [8:0]  memAddr_q;
    logic [31:0] memWdata_q;
    logic [7:0]  errCnt_q;
`ifdef UART_MEM_CMD_TIMEOUT_EN
    logic [31:0] idleCnt_q;
`endif

    logic        rxHexOk;
    logic [3:0]  rxNib;
    logic [3:0]  bankLimit;
    logic        tgtValid;

    function automatic logic [7:0] errInc(input logic [7:0] e);
        return (e == 8'hFF) ? e : e + 8'd1;
    endfunction

    function automatic logic [7:0] hexChar(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Decode the rx head byte as a hex digit and qualify the current target.
    always_comb begin
        rxHexOk = 1'b0;
        rxNib   = 4'h0;
        if (r_data >= 8'h30 && r_data <= 8'h39) begin
            rxHexOk = 1'b1;
            rxNib   = r_data[3:0];
        end else if ((r_data >= 8'h41 && r_data <= 8'h46) ||
                     (r_data >= 8'h61 && r_data <= 8'h66)) begin
            rxHexOk = 1'b1;
            rxNib   = r_data[3:0] + 4'd9;
        end
        case (program_sel)
            2'b11:   bankLimit = 4'd3;
            2'b10:   bankLimit = 4'd5;
            2'b01:   bankLimit = 4'd4;
            default: bankLimit = 4'd0;
        endcase
        if (addr_q[13]) tgtValid = (program_sel != 2'b00);
        else            tgtValid = (addr_q[12:9] < bankLimit);
    end

    // Command FSM; every output is registered and strobes default low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            gap_q        <= 1'b0;
            cmdByte_q    <= '0;
            nibCnt_q     <= '0;
            shift_q      <= '0;
            addr_q       <= '0;
            waitCnt_q    <= '0;
            sendIdx_q    <= '0;
            rdUart_q     <= 1'b0;
            wData_q      <= '0;
            wrUart_q     <= 1'b0;
            memEn_q      <= 1'b0;
            memWe_q      <= 1'b0;
            memMainSel_q <= 1'b0;
            memBank_q    <= '0;
            memAddr_q    <= '0;
            memWdata_q   <= '0;
            errCnt_q     <= '0;
`ifdef UART_MEM_CMD_TIMEOUT_EN
            idleCnt_q    <= '0;
`endif
        end else begin
            rdUart_q     <= 1'b0;
            wrUart_q     <= 1'b0;
            gap_q        <= 1'b0;
            memEn_q      <= 1'b0;
            memWe_q      <= 1'b0;
            memMainSel_q <= 1'b0;
            memBank_q    <= '0;
            memAddr_q    <= '0;
            memWdata_q   <= '0;
`ifdef UART_MEM_CMD_TIMEOUT_EN
            idleCnt_q    <= '0;
`endif
            case (state_q)
                IDLE: begin
                    if (!gap_q && !rx_empty) begin
                        rdUart_q  <= 1'b1;
                        gap_q     <= 1'b1;
                        cmdByte_q <= r_data;
                        state_q   <= CMD;
                    end
                end
                CMD: begin
                    nibCnt_q <= '0;
                    shift_q  <= '0;
                    case (cmdByte_q)
                        8'h52, 8'h72: state_q <= ADDR;
                        8'h57, 8'h77: state_q <= DATA;
                        default:      state_q <= IDLE;
                    endcase
                end
                ADDR, DATA: begin
                    if (!gap_q && !rx_empty) begin
                        rdUart_q <= 1'b1;
                        gap_q    <= 1'b1;
                        if (!rxHexOk) begin
                            errCnt_q <= errInc(errCnt_q);
                            state_q  <= IDLE;
                        end else begin
                            shift_q  <= {shift_q[27:0], rxNib};
                            nibCnt_q <= nibCnt_q + 3'd1;
                            if (state_q == ADDR && nibCnt_q == 3'd3) begin
                                addr_q  <= {shift_q[9:0], rxNib};
                                state_q <= MRD;
                            end else if (state_q == DATA && nibCnt_q == 3'd7) begin
                                state_q <= MWR;
                            end
                        end
                    end
`ifdef UART_MEM_CMD_TIMEOUT_EN
                    else if (idleCnt_q >= 32'(TIMEOUT_CYCLES - 1)) begin
                        errCnt_q <= errInc(errCnt_q);
                        state_q  <= IDLE;
                    end else begin
                        idleCnt_q <= idleCnt_q + 32'd1;
                    end
`endif
                end
                MWR: begin
                    if (tgtValid) begin
                        memEn_q      <= 1'b1;
                        memWe_q      <= 1'b1;
                        memWdata_q   <= shift_q;
                        memMainSel_q <= addr_q[13];
                        memBank_q    <= addr_q[13] ? 4'h0 : addr_q[12:9];
                        memAddr_q    <= addr_q[13] ? {3'b000, addr_q[5:0]} : addr_q[8:0];
                    end else begin
                        errCnt_q <= errInc(errCnt_q);
                    end
                    addr_q  <= addr_q + 14'd1;
                    state_q <= IDLE;
                end
                MRD: begin
                    sendIdx_q <= '0;
                    if (tgtValid) begin
                        memEn_q      <= 1'b1;
                        memMainSel_q <= addr_q[13];
                        memBank_q    <= addr_q[13] ? 4'h0 : addr_q[12:9];
                        memAddr_q    <= addr_q[13] ? {3'b000, addr_q[5:0]} : addr_q[8:0];
                        waitCnt_q    <= '0;
                        state_q      <= MWAIT;
                    end else begin
                        shift_q  <= '0;
                        errCnt_q <= errInc(errCnt_q);
                        state_q  <= SEND;
                    end
                end
                MWAIT: begin
                    if (waitCnt_q == 3'(RD_LATENCY)) begin
                        shift_q <= mem_rdata;
                        state_q <= SEND;
                    end else begin
                        waitCnt_q <= waitCnt_q + 3'd1;
                    end
                end
                SEND: begin
                    if (!tx_full && !wrUart_q) begin
                        wrUart_q  <= 1'b1;
                        wData_q   <= hexChar(shift_q[31:28]);
                        shift_q   <= {shift_q[27:0], 4'h0};
                        sendIdx_q <= sendIdx_q + 3'd1;
                        if (sendIdx_q == 3'd7) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_uart      = rdUart_q;
    assign w_data       = wData_q;
    assign wr_uart      = wrUart_q;
    assign mem_en       = memEn_q;
    assign mem_we       = memWe_q;
    assign mem_main_sel = memMainSel_q;
    assign mem_bank     = memBank_q;
    assign mem_addr     = memAddr_q;
    assign mem_wdata    = memWdata_q;
    assign busy         = (state_q != IDLE);
    assign err_cnt      = errCnt_q;

endmodule

// File: tb/tb_uart_mem_cmd_ctrl.sv
// Self-checking bench for uart_mem_cmd_ctrl: a FIFO/memory model driven from
// a single process, a table of command vectors, and hand-written sequences
// for tx stall, mid-command reset and error-count saturation.
module tb_uart_mem_cmd_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  program_sel;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        rd_uart;
    logic        tx_full;
    logic [7:0]  w_data;
    logic        wr_uart;
    logic        mem_en;
    logic        mem_we;
    logic        mem_main_sel;
    logic [3:0]  mem_bank;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [7:0]  err_cnt;

    uart_mem_cmd_ctrl #(.RD_LATENCY(LAT), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .reset(reset), .program_sel(program_sel),
        .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
        .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart),
        .mem_en(mem_en), .mem_we(mem_we), .mem_main_sel(mem_main_sel),
        .mem_bank(mem_bank), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       cmd;
        logic [1:0]  psel;
        bit          expMem;
        bit          expWe;
        bit          expMain;
        logic [3:0]  bank;
        logic [8:0]  addr;
        logic [31:0] wdata;
        int          txLen;
        logic [63:0] tx;
        logic [7:0]  err;
    } vec_t;

    vec_t        vecs[$];
    logic [7:0]  rxQ[$];
    logic [31:0] memModel[int];
    int          checks = 0;
    int          failures = 0;
    int          memEnCnt, txCnt, rdWait, rdKey;
    logic [63:0] txWord;
    logic        lastWe, lastMain;
    logic [3:0]  lastBank;
    logic [8:0]  lastAddr;
    logic [31:0] lastWdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic updRx();
        rx_empty = (rxQ.size() == 0);
        r_data   = (rxQ.size() != 0) ? rxQ[0] : 8'h00;
    endtask

    // Models the rx FIFO pop, tx FIFO capture and a latency-LAT memory.
    task automatic monitor();
        logic [31:0] rd;
        int key;
        rd = 32'hDEADBEEF;
        if (rdWait > 0) begin
            rdWait--;
            if (rdWait == 0) rd = memModel.exists(rdKey) ? memModel[rdKey] : 32'h0;
        end
        if (mem_en) begin
            key = int'({mem_main_sel, mem_bank, mem_addr});
            memEnCnt++;
            lastWe = mem_we; lastMain = mem_main_sel; lastBank = mem_bank;
            lastAddr = mem_addr; lastWdata = mem_wdata;
            if (mem_we) memModel[key] = mem_wdata;
            else begin rdKey = key; rdWait = LAT; end
        end
        mem_rdata = rd;
        if (rd_uart && rxQ.size() != 0) begin
            void'(rxQ.pop_front());
            updRx();
        end
        if (wr_uart) begin
            txWord = {txWord[55:0], w_data};
            txCnt++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #2;
    endtask

    task automatic clearObs();
        memEnCnt = 0; txCnt = 0; txWord = '0;
    endtask

    task automatic applyStimulus(input string s);
        for (int i = 0; i < s.len(); i++) rxQ.push_back(s[i]);
        updRx();
    endtask

    task automatic waitIdle(input string name, input int budget);
        bit done = 0;
        int n = 0;
        while (!done && n < budget) begin
            tick();
            if (rxQ.size() == 0 && !busy && !rd_uart) done = 1;
            n++;
        end
        check({name, " idle"}, 64'(done), 64'd1);
        repeat (3) tick();
    endtask

    task automatic checkResetOutputs(input string name);
        check({name, " ctl"}, {rd_uart, w_data, wr_uart, mem_en, mem_we, mem_main_sel, busy, err_cnt},
              '0);
        check({name, " mem"}, {mem_bank, mem_addr, mem_wdata}, '0);
    endtask

    task automatic checkOutput(input string name, input vec_t v);
        check({name, " memEn"}, 64'(memEnCnt), v.expMem ? 64'd1 : 64'd0);
        if (v.expMem) begin
            check({name, " target"}, {lastWe, lastMain, lastBank, lastAddr},
                  {v.expWe, v.expMain, v.bank, v.addr});
            if (v.expWe) check({name, " wdata"}, lastWdata, v.wdata);
        end
        check({name, " txCnt"}, 64'(txCnt), 64'(v.txLen));
        check({name, " txData"}, txWord, v.tx);
        check({name, " err"}, err_cnt, v.err);
    endtask

    initial begin
        string s;
        reset = 1'b1; program_sel = 2'b00; tx_full = 1'b0;
        mem_rdata = 32'hDEADBEEF; rdWait = 0; rdKey = 0;
        clearObs();
        updRx();
        repeat (2) tick();
        checkResetOutputs("reset");
        reset = 1'b0;
        tick();

        // Command vectors with hand-computed targets, replies and error counts.
        vecs.push_back('{cmd:"R015E", psel:2'b11, expMem:1, expWe:0, expMain:0, bank:4'h0, addr:9'h15E, wdata:32'h0, txLen:8, tx:"00000000", err:8'h00});
        vecs.push_back('{cmd:"W01234567", psel:2'b11, expMem:1, expWe:1, expMain:0, bank:4'h0, addr:9'h15E, wdata:32'h01234567, txLen:0, tx:64'h0, err:8'h00});
        vecs.push_back('{cmd:"W89ABCDEF", psel:2'b11, expMem:1, expWe:1, expMain:0, bank:4'h0, addr:9'h15F, wdata:32'h89ABCDEF, txLen:0, tx:64'h0, err:8'h00});
        vecs.push_back('{cmd:"r015f", psel:2'b11, expMem:1, expWe:0, expMain:0, bank:4'h0, addr:9'h15F, wdata:32'h0, txLen:8, tx:"89ABCDEF", err:8'h00});
        vecs.push_back('{cmd:"R015E", psel:2'b11, expMem:1, expWe:0, expMain:0, bank:4'h0, addr:9'h15E, wdata:32'h0, txLen:8, tx:"01234567", err:8'h00});
        vecs.push_back('{cmd:"R0643", psel:2'b11, expMem:0, expWe:0, expMain:0, bank:4'h0, addr:9'h0, wdata:32'h0, txLen:8, tx:"00000000", err:8'h01});
        vecs.push_back('{cmd:"R0643", psel:2'b10, expMem:1, expWe:0, expMain:0, bank:4'h3, addr:9'h043, wdata:32'h0, txLen:8, tx:"00000000", err:8'h01});
        vecs.push_back('{cmd:"W0000000a", psel:2'b10, expMem:1, expWe:1, expMain:0, bank:4'h3, addr:9'h043, wdata:32'h0000000A, txLen:0, tx:64'h0, err:8'h01});
        vecs.push_back('{cmd:"W12345678", psel:2'b01, expMem:1, expWe:1, expMain:0, bank:4'h3, addr:9'h044, wdata:32'h12345678, txLen:0, tx:64'h0, err:8'h01});
        vecs.push_back('{cmd:"W11111111", psel:2'b00, expMem:0, expWe:0, expMain:0, bank:4'h0, addr:9'h0, wdata:32'h0, txLen:0, tx:64'h0, err:8'h02});
        vecs.push_back('{cmd:"R3FFF", psel:2'b01, expMem:1, expWe:0, expMain:1, bank:4'h0, addr:9'h03F, wdata:32'h0, txLen:8, tx:"00000000", err:8'h02});
        vecs.push_back('{cmd:"WDEADBEEF", psel:2'b01, expMem:1, expWe:1, expMain:1, bank:4'h0, addr:9'h03F, wdata:32'hDEADBEEF, txLen:0, tx:64'h0, err:8'h02});
        vecs.push_back('{cmd:"WCAFEF00D", psel:2'b01, expMem:1, expWe:1, expMain:0, bank:4'h0, addr:9'h000, wdata:32'hCAFEF00D, txLen:0, tx:64'h0, err:8'h02});
        vecs.push_back('{cmd:"R3FFF", psel:2'b01, expMem:1, expWe:0, expMain:1, bank:4'h0, addr:9'h03F, wdata:32'h0, txLen:8, tx:"DEADBEEF", err:8'h02});
        vecs.push_back('{cmd:"X", psel:2'b11, expMem:0, expWe:0, expMain:0, bank:4'h0, addr:9'h0, wdata:32'h0, txLen:0, tx:64'h0, err:8'h02});
        vecs.push_back('{cmd:"R01G5", psel:2'b11, expMem:0, expWe:0, expMain:0, bank:4'h0, addr:9'h0, wdata:32'h0, txLen:0, tx:64'h0, err:8'h03});
        vecs.push_back('{cmd:"W55555555", psel:2'b01, expMem:1, expWe:1, expMain:1, bank:4'h0, addr:9'h03F, wdata:32'h55555555, txLen:0, tx:64'h0, err:8'h03});
        vecs.push_back('{cmd:"R015E", psel:2'b11, expMem:1, expWe:0, expMain:0, bank:4'h0, addr:9'h15E, wdata:32'h0, txLen:8, tx:"01234567", err:8'h03});

        foreach (vecs[i]) begin
            string name;
            name = $sformatf("v%0d %s", i, vecs[i].cmd);
            clearObs();
            program_sel = vecs[i].psel;
            applyStimulus(vecs[i].cmd);
            waitIdle(name, 200);
            checkOutput(name, vecs[i]);
        end

        // tx_full held high: the reply must wait, then arrive complete and in order.
        clearObs();
        program_sel = 2'b11;
        tx_full = 1'b1;
        applyStimulus("R015F");
        repeat (50) tick();
        check("stall noPush", 64'(txCnt), 64'd0);
        check("stall busy", 64'(busy), 64'd1);
        tx_full = 1'b0;
        waitIdle("stall", 200);
        check("stall txCnt", 64'(txCnt), 64'd8);
        check("stall txData", txWord, "89ABCDEF");

        // Reset in the middle of a write command discards it.
        clearObs();
        applyStimulus("W0123");
        for (int n = 0; n < 50 && rxQ.size() != 0; n++) tick();
        repeat (2) tick();
        check("midcmd busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        checkResetOutputs("midreset");
        repeat (2) tick();
        reset = 1'b0;
        tick();
        clearObs();
        program_sel = 2'b01;
        applyStimulus("R2000");
        waitIdle("R2000", 200);
        check("R2000 memEn", 64'(memEnCnt), 64'd1);
        check("R2000 target", {lastWe, lastMain, lastBank, lastAddr}, {1'b0, 1'b1, 4'h0, 9'h000});
        check("R2000 txData", txWord, "00000000");
        check("R2000 err", err_cnt, 8'h00);

        // Error counter saturates at FF.
        clearObs();
        s = "";
        for (int i = 0; i < 260; i++) s = {s, "RG"};
        applyStimulus(s);
        waitIdle("saturate", 4000);
        check("saturate err", err_cnt, 8'hFF);
        check("saturate memEn", 64'(memEnCnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
